// File: rtl/snitch_regfile_pkg.sv
// -----------------------------------------------------------------------------
// snitch_regfile_pkg
//   Shared definitions for the Snitch register file with scoreboard.
//   - num_words():    number of registers for a given address width.
//   - winning_port(): priority encoder over the write ports for one register
//                     address. The highest-index enabled port that hits wins.
//   The encoder works on fixed maximum widths (MaxWritePorts, MaxAddrWidth).
//   Callers zero-extend their write-port vectors to these widths.
// -----------------------------------------------------------------------------
package snitch_regfile_pkg;

   localparam int unsigned MaxWritePorts = 8;
   localparam int unsigned MaxAddrWidth  = 8;
   localparam int unsigned PortIdxWidth  = $clog2(MaxWritePorts);

   typedef struct packed {
      logic                    hit;
      logic [PortIdxWidth-1:0] idx;
   } wport_sel_t;

   function automatic int unsigned num_words(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

   // Later iterations override earlier ones, so the highest-index port wins.
   function automatic wport_sel_t winning_port(
      input logic [MaxWritePorts-1:0]                   we,
      input logic [MaxWritePorts-1:0][MaxAddrWidth-1:0] waddr,
      input logic [MaxAddrWidth-1:0]                    addr
   );
      wport_sel_t sel;
      sel = '0;
      for (int unsigned p = 0; p < MaxWritePorts; p++) begin
         if (we[p] && (waddr[p] == addr)) begin
            sel.hit = 1'b1;
            sel.idx = PortIdxWidth'(p);
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/snitch_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// snitch_regfile_scoreboard
//   Per-register busy tracking for long-latency writebacks.
//   Ports:
//     clk_i, rst_ni  clock, asynchronous active-low reset
//     claim_i        issue wants to mark claim_addr_i busy
//     claim_addr_i   register being claimed
//     clr_i          per-register busy-retire requests from the write ports
//     claim_gnt_o    claim accepted this cycle
//     busy_q_o       registered busy vector
//     busy_d_o       next-state busy vector (used for bypassed rbusy)
//
//   The grant looks only at the registered busy bit. A clear landing in the
//   same cycle does not make a refused claim succeed: issue retries instead.
//   On the same register, set beats clear, because a new producer was issued.
// -----------------------------------------------------------------------------
module snitch_regfile_scoreboard
   import snitch_regfile_pkg::*;
#(
   parameter int unsigned AddrWidth   = 5,
   parameter bit          ZeroRegZero = 1'b1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      claim_i,
   input  logic [AddrWidth-1:0]      claim_addr_i,
   input  logic [(2**AddrWidth)-1:0] clr_i,
   output logic                      claim_gnt_o,
   output logic [(2**AddrWidth)-1:0] busy_q_o,
   output logic [(2**AddrWidth)-1:0] busy_d_o
);

   localparam int unsigned NumWords = num_words(AddrWidth);

   logic [NumWords-1:0] busy_q, busy_d;
   logic [NumWords-1:0] set, clr;
   logic                zero_claim;

   // Register 0 is always claimable and never becomes busy.
   assign zero_claim  = ZeroRegZero && (claim_addr_i == '0);
   assign claim_gnt_o = claim_i && (zero_claim || !busy_q[claim_addr_i]);

   always_comb begin
      set = '0;
      if (claim_gnt_o && !zero_claim) begin
         set[claim_addr_i] = 1'b1;
      end
      clr = clr_i;
      if (ZeroRegZero) begin
         clr[0] = 1'b0;
      end
      busy_d = set | (busy_q & ~clr);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_q_o = busy_q;
   assign busy_d_o = busy_d;

endmodule

// File: rtl/snitch_regfile_sb.sv
// -----------------------------------------------------------------------------
// snitch_regfile_sb
//   Flip-flop register file with N prioritised write ports, optional
//   write-to-read bypass and an integrated busy scoreboard.
//   Ports:
//     clk_i, rst_ni  clock, asynchronous active-low reset
//     raddr_i        NrReadPorts packed read addresses
//     rdata_o        NrReadPorts packed read data (combinational)
//     rbusy_o        busy flag of each read address
//     waddr_i        NrWritePorts packed write addresses
//     wdata_i        NrWritePorts packed write data
//     we_i           write enables
//     wclr_i         write also retires the busy bit of its address
//     claim_i        issue requests to mark claim_addr_i busy
//     claim_addr_i   register to claim
//     claim_gnt_o    claim accepted this cycle
//     busy_o         registered busy vector
//   Limits: NrWritePorts <= 8 and AddrWidth <= 8. These are the widths of the
//   priority encoder in snitch_regfile_pkg.
// -----------------------------------------------------------------------------
module snitch_regfile_sb
   import snitch_regfile_pkg::*;
#(
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned AddrWidth    = 5,
   parameter int unsigned NrReadPorts  = 3,
   parameter int unsigned NrWritePorts = 2,
   parameter bit          ZeroRegZero  = 1'b1,
   parameter bit          Bypass       = 1'b1
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [NrReadPorts*AddrWidth-1:0]  raddr_i,
   output logic [NrReadPorts*DataWidth-1:0]  rdata_o,
   output logic [NrReadPorts-1:0]            rbusy_o,
   input  logic [NrWritePorts*AddrWidth-1:0] waddr_i,
   input  logic [NrWritePorts*DataWidth-1:0] wdata_i,
   input  logic [NrWritePorts-1:0]           we_i,
   input  logic [NrWritePorts-1:0]           wclr_i,
   input  logic                              claim_i,
   input  logic [AddrWidth-1:0]              claim_addr_i,
   output logic                              claim_gnt_o,
   output logic [(2**AddrWidth)-1:0]         busy_o
);

   localparam int unsigned NumWords = num_words(AddrWidth);

   logic [MaxWritePorts-1:0]                   we_ext;
   logic [MaxWritePorts-1:0][MaxAddrWidth-1:0] waddr_ext;
   logic [MaxWritePorts-1:0][DataWidth-1:0]    wdata_ext;
   logic [NumWords-1:0]                        clr;
   logic [NumWords-1:0]                        busy_q, busy_d;
   logic [NumWords-1:0][DataWidth-1:0]         rf_q;

   // Unpack the write ports into the encoder's fixed-width form.
   // Also collect the per-register busy clears.
   always_comb begin
      we_ext    = '0;
      waddr_ext = '0;
      wdata_ext = '0;
      clr       = '0;
      for (int unsigned p = 0; p < NrWritePorts; p++) begin
         we_ext[p]    = we_i[p];
         waddr_ext[p] = MaxAddrWidth'(waddr_i[p*AddrWidth +: AddrWidth]);
         wdata_ext[p] = wdata_i[p*DataWidth +: DataWidth];
         if (we_i[p] && wclr_i[p]) begin
            clr[waddr_i[p*AddrWidth +: AddrWidth]] = 1'b1;
         end
      end
   end

   snitch_regfile_scoreboard #(
      .AddrWidth   (AddrWidth),
      .ZeroRegZero (ZeroRegZero)
   ) i_scoreboard (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .claim_i      (claim_i),
      .claim_addr_i (claim_addr_i),
      .clr_i        (clr),
      .claim_gnt_o  (claim_gnt_o),
      .busy_q_o     (busy_q),
      .busy_d_o     (busy_d)
   );

   assign busy_o = busy_q;

   // Data array: one enable-gated word per register. Each word is loaded from
   // the winning write port. Register 0 is never enabled when ZeroRegZero is set.
   for (genvar r = 0; r < NumWords; r++) begin : g_word
      wport_sel_t           sel;
      logic                 en;
      logic [DataWidth-1:0] word_d, word_q;

      always_comb begin
         sel    = winning_port(we_ext, waddr_ext, MaxAddrWidth'(r));
         en     = sel.hit && !(ZeroRegZero && (r == 0));
         word_d = wdata_ext[sel.idx];
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            word_q <= '0;
         end else if (en) begin
            word_q <= word_d;
         end
      end

      assign rf_q[r] = word_q;
   end

   // Read ports. With Bypass set, a same-cycle write that hits the read
   // address forwards the winning port's data. The busy flag is taken from
   // the next-state vector.
   for (genvar q = 0; q < NrReadPorts; q++) begin : g_read
      logic [AddrWidth-1:0] addr;
      wport_sel_t           sel;
      logic [DataWidth-1:0] rd;

      assign addr = raddr_i[q*AddrWidth +: AddrWidth];

      always_comb begin
         sel = winning_port(we_ext, waddr_ext, MaxAddrWidth'(addr));
         rd  = rf_q[addr];
         if (Bypass && sel.hit) begin
            rd = wdata_ext[sel.idx];
         end
         if (ZeroRegZero && (addr == '0)) begin
            rd = '0;
         end
      end

      assign rdata_o[q*DataWidth +: DataWidth] = rd;
      assign rbusy_o[q] = Bypass ? busy_d[addr] : busy_q[addr];
   end

endmodule
